// File: rtl/can_fault_confinement_ctrl.sv
// can_fault_confinement_ctrl: CAN TEC/REC error-state keeper and error/overload frame request scheduler
module can_fault_confinement_ctrl #(
  parameter int unsigned PASSIVE_LIM = 128,
  parameter int unsigned BUSOFF_LIM  = 256,
  parameter int unsigned MAX_OVRLD   = 2,
  parameter int unsigned RECOV_SEQS  = 128,
  parameter int unsigned DONE_TMO    = 64
) (
  input  logic       SP,
  input  logic       reset,
  input  logic       RX,
  input  logic       ERR_BIT,
  input  logic       ERR_IS_TX,
  input  logic       TX_OK,
  input  logic       RX_OK,
  input  logic       OVRLD_REQ,
  input  logic       F_ITMSS,
  output logic       F_OVRLD,
  output logic       FLAG_KIND,
  output logic       FLAG_PASSIVE,
  output logic [8:0] TEC,
  output logic [7:0] REC,
  output logic [1:0] ERR_STATE,
  output logic       BUSY
);
  localparam int OVL_W = $clog2(MAX_OVRLD + 1);
  localparam int SEQ_W = $clog2(RECOV_SEQS + 1);
  localparam int TMO_W = $clog2(DONE_TMO + 1);
  localparam logic [8:0] TEC_PAS = 9'(PASSIVE_LIM);
  localparam logic [7:0] REC_PAS = 8'(PASSIVE_LIM);
  localparam logic [8:0] TEC_OFF = 9'(BUSOFF_LIM);
  localparam logic [OVL_W-1:0] OVL_MAX = OVL_W'(MAX_OVRLD);
  localparam logic [SEQ_W-1:0] SEQ_MAX = SEQ_W'(RECOV_SEQS);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(DONE_TMO);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE, BUSOFF} state_t;

  state_t state_q, state_d;
  logic [8:0] tec_q, tec_d;
  logic [7:0] rec_q, rec_d;
  logic busoff_q, busoff_d, kind_q, kind_d, passive_q, passive_d;
  logic [OVL_W-1:0] ovl_q, ovl_d, ovl_base;
  logic [3:0] bit_q, bit_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic upd, take_err, take_ovl, recov;

  // state and datapath registers, all cleared asynchronously
  always_ff @(posedge SP or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tec_q     <= '0;
      rec_q     <= '0;
      busoff_q  <= 1'b0;
      kind_q    <= 1'b0;
      passive_q <= 1'b0;
      ovl_q     <= '0;
      bit_q     <= '0;
      seq_q     <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      tec_q     <= tec_d;
      rec_q     <= rec_d;
      busoff_q  <= busoff_d;
      kind_q    <= kind_d;
      passive_q <= passive_d;
      ovl_q     <= ovl_d;
      bit_q     <= bit_d;
      seq_q     <= seq_d;
      tmo_q     <= tmo_d;
    end
  end

  // counter updates, bus-off recovery, request arbitration and next state
  always_comb begin
    upd   = state_q != BUSOFF;
    tec_d = tec_q;
    rec_d = rec_q;
    if (upd && ERR_BIT && ERR_IS_TX) tec_d = (tec_q > 9'd503) ? 9'd511 : tec_q + 9'd8;
    if (upd && TX_OK && tec_d != '0) tec_d = tec_d - 9'd1;
    if (upd && ERR_BIT && !ERR_IS_TX && rec_q != '1) rec_d = rec_q + 8'd1;
    if (upd && RX_OK) rec_d = (rec_d > 8'd127) ? 8'd120 : (rec_d != '0) ? rec_d - 8'd1 : rec_d;
    busoff_d = busoff_q | (upd && tec_d >= TEC_OFF);
    bit_d = '0;
    seq_d = seq_q;
    if (!upd && RX) begin
      bit_d = (bit_q == 4'd10) ? '0 : bit_q + 4'd1;
      seq_d = (bit_q == 4'd10) ? seq_q + 1'b1 : seq_q;
    end
    recov    = !upd && seq_d == SEQ_MAX;
    ovl_base = (TX_OK || RX_OK) ? '0 : ovl_q;
    take_err = state_q == IDLE && ERR_BIT && !busoff_d;
    take_ovl = state_q == IDLE && OVRLD_REQ && !ERR_BIT && !busoff_d && ovl_base < OVL_MAX;
    ovl_d     = take_ovl ? ovl_base + 1'b1 : ovl_base;
    kind_d    = take_err ? 1'b1 : take_ovl ? 1'b0 : kind_q;
    passive_d = take_err ? (tec_d >= TEC_PAS || rec_d >= REC_PAS) : take_ovl ? 1'b0 : passive_q;
    tmo_d     = (state_q == WAIT_DONE) ? tmo_q + 1'b1 : '0;
    if (recov) begin
      tec_d    = '0;
      rec_d    = '0;
      busoff_d = 1'b0;
      bit_d    = '0;
      seq_d    = '0;
      ovl_d    = '0;
    end
    state_d = busoff_d ? BUSOFF :
              (state_q == IDLE)      ? ((take_err || take_ovl) ? REQ : IDLE) :
              (state_q == REQ)       ? WAIT_DONE :
              (state_q == WAIT_DONE) ? ((!F_ITMSS || tmo_d == TMO_MAX) ? IDLE : WAIT_DONE) :
              IDLE;
  end

  // outputs decoded from registered state
  always_comb begin
    F_OVRLD      = state_q != REQ;
    BUSY         = state_q != IDLE;
    FLAG_KIND    = kind_q;
    FLAG_PASSIVE = passive_q;
    TEC          = tec_q;
    REC          = rec_q;
    ERR_STATE    = busoff_q ? 2'b10 : (tec_q >= TEC_PAS || rec_q >= REC_PAS) ? 2'b01 : 2'b00;
  end
endmodule

// File: tb/tb_can_fault_confinement_ctrl.sv
// tb_can_fault_confinement_ctrl: directed self-checking bench for the fault-confinement controller
module tb_can_fault_confinement_ctrl;
  logic SP = 0, reset = 1, RX = 0, ERR_BIT = 0, ERR_IS_TX = 0, TX_OK = 0, RX_OK = 0, OVRLD_REQ = 0, F_ITMSS = 1;
  logic F_OVRLD, FLAG_KIND, FLAG_PASSIVE, BUSY;
  logic [8:0] TEC;
  logic [7:0] REC;
  logic [1:0] ERR_STATE;
  int vec = 0, errs = 0, strobes = 0, s0;

  can_fault_confinement_ctrl dut (
    .SP(SP), .reset(reset), .RX(RX), .ERR_BIT(ERR_BIT), .ERR_IS_TX(ERR_IS_TX),
    .TX_OK(TX_OK), .RX_OK(RX_OK), .OVRLD_REQ(OVRLD_REQ), .F_ITMSS(F_ITMSS),
    .F_OVRLD(F_OVRLD), .FLAG_KIND(FLAG_KIND), .FLAG_PASSIVE(FLAG_PASSIVE),
    .TEC(TEC), .REC(REC), .ERR_STATE(ERR_STATE), .BUSY(BUSY)
  );

  always #5 SP = ~SP;

  always @(negedge SP) if (F_OVRLD === 1'b0) strobes++;

  task step;
    @(posedge SP);
    #1;
  endtask

  task finish_frame;
    F_ITMSS = 0;
    step;
    F_ITMSS = 1;
  endtask

  task err_req(input logic tx);
    ERR_BIT = 1;
    ERR_IS_TX = tx;
    step;
    ERR_BIT = 0;
    ERR_IS_TX = 0;
  endtask

  task apply_reset;
    reset = 1;
    #2;
    reset = 0;
    step;
  endtask

  task test_reset;
    step;
    reset = 0;
    step;
    vec++; if ({F_OVRLD, FLAG_KIND, FLAG_PASSIVE, TEC, REC, ERR_STATE, BUSY} !== {1'b1, 2'b00, 9'd0, 8'd0, 2'b00, 1'b0}) begin errs++; $display("FAIL reset_vals got %b exp 1_00_0_0_00_0", {F_OVRLD, FLAG_KIND, FLAG_PASSIVE, TEC, REC, ERR_STATE, BUSY}); end
  endtask

  task test_tx_error;
    err_req(1);
    vec++; if ({F_OVRLD, FLAG_KIND, BUSY, TEC} !== {1'b0, 1'b1, 1'b1, 9'd8}) begin errs++; $display("FAIL tx_err_strobe got ovrld=%b kind=%b busy=%b tec=%0d exp 0 1 1 8", F_OVRLD, FLAG_KIND, BUSY, TEC); end
    step;
    vec++; if ({F_OVRLD, BUSY} !== 2'b11) begin errs++; $display("FAIL strobe_one_cycle got ovrld=%b busy=%b exp 1 1", F_OVRLD, BUSY); end
    repeat (3) step;
    vec++; if (BUSY !== 1'b1) begin errs++; $display("FAIL busy_wait got %b exp 1", BUSY); end
    finish_frame;
    vec++; if (BUSY !== 1'b0) begin errs++; $display("FAIL busy_done got %b exp 0", BUSY); end
  endtask

  task test_passive_busoff;
    for (int i = 2; i <= 32; i++) begin
      err_req(1);
      if (i == 15) begin
        vec++; if ({TEC, FLAG_PASSIVE, ERR_STATE} !== {9'd120, 1'b0, 2'b00}) begin errs++; $display("FAIL err15 got tec=%0d pas=%b st=%b exp 120 0 00", TEC, FLAG_PASSIVE, ERR_STATE); end
      end
      if (i == 16) begin
        vec++; if ({TEC, FLAG_PASSIVE, ERR_STATE} !== {9'd128, 1'b1, 2'b01}) begin errs++; $display("FAIL err16 got tec=%0d pas=%b st=%b exp 128 1 01", TEC, FLAG_PASSIVE, ERR_STATE); end
      end
      if (i == 17) begin
        vec++; if ({F_OVRLD, FLAG_KIND, FLAG_PASSIVE, TEC} !== {1'b0, 1'b1, 1'b1, 9'd136}) begin errs++; $display("FAIL err17 got ovrld=%b kind=%b pas=%b tec=%0d exp 0 1 1 136", F_OVRLD, FLAG_KIND, FLAG_PASSIVE, TEC); end
      end
      if (i == 32) begin
        vec++; if ({TEC, ERR_STATE, F_OVRLD, BUSY} !== {9'd256, 2'b10, 1'b1, 1'b1}) begin errs++; $display("FAIL busoff_entry got tec=%0d st=%b ovrld=%b busy=%b exp 256 10 1 1", TEC, ERR_STATE, F_OVRLD, BUSY); end
      end
      if (i < 32) begin
        step;
        finish_frame;
      end
    end
  endtask

  task test_busoff_recovery;
    s0 = strobes;
    err_req(1);
    step;
    vec++; if ({TEC, ERR_STATE} !== {9'd256, 2'b10} || strobes != s0) begin errs++; $display("FAIL busoff_ignore got tec=%0d st=%b strobes=%0d exp 256 10 0", TEC, ERR_STATE, strobes - s0); end
    RX = 1;
    repeat (5) step;
    RX = 0;
    step;
    RX = 1;
    repeat (1407) step;
    vec++; if ({ERR_STATE, BUSY} !== {2'b10, 1'b1}) begin errs++; $display("FAIL recov_early got st=%b busy=%b exp 10 1", ERR_STATE, BUSY); end
    step;
    RX = 0;
    vec++; if ({TEC, REC, ERR_STATE, BUSY} !== {9'd0, 8'd0, 2'b00, 1'b0}) begin errs++; $display("FAIL recov_done got tec=%0d rec=%0d st=%b busy=%b exp 0 0 00 0", TEC, REC, ERR_STATE, BUSY); end
  endtask

  task test_overload;
    apply_reset;
    s0 = strobes;
    for (int i = 0; i < 3; i++) begin
      OVRLD_REQ = 1;
      step;
      OVRLD_REQ = 0;
      vec++; if (F_OVRLD !== (i < 2 ? 1'b0 : 1'b1)) begin errs++; $display("FAIL ovl_req%0d got ovrld=%b exp %b", i, F_OVRLD, (i < 2 ? 1'b0 : 1'b1)); end
      if (i == 0) begin
        vec++; if ({FLAG_KIND, FLAG_PASSIVE} !== 2'b00) begin errs++; $display("FAIL ovl_kind got %b exp 00", {FLAG_KIND, FLAG_PASSIVE}); end
      end
      step;
      finish_frame;
    end
    vec++; if (strobes - s0 != 2) begin errs++; $display("FAIL ovl_limit got %0d strobes exp 2", strobes - s0); end
    RX_OK = 1;
    step;
    RX_OK = 0;
    OVRLD_REQ = 1;
    step;
    OVRLD_REQ = 0;
    vec++; if (F_OVRLD !== 1'b0) begin errs++; $display("FAIL ovl_after_rxok got ovrld=%b exp 0", F_OVRLD); end
    step;
    finish_frame;
    vec++; if (strobes - s0 != 3) begin errs++; $display("FAIL ovl_total got %0d strobes exp 3", strobes - s0); end
  endtask

  task test_simultaneous;
    apply_reset;
    s0 = strobes;
    ERR_BIT = 1;
    OVRLD_REQ = 1;
    step;
    ERR_BIT = 0;
    OVRLD_REQ = 0;
    vec++; if ({F_OVRLD, FLAG_KIND, REC} !== {1'b0, 1'b1, 8'd1}) begin errs++; $display("FAIL err_wins got ovrld=%b kind=%b rec=%0d exp 0 1 1", F_OVRLD, FLAG_KIND, REC); end
    step;
    finish_frame;
    vec++; if (strobes - s0 != 1) begin errs++; $display("FAIL single_strobe got %0d exp 1", strobes - s0); end
    repeat (129) begin
      err_req(0);
      step;
      finish_frame;
    end
    vec++; if ({REC, ERR_STATE, FLAG_PASSIVE} !== {8'd130, 2'b01, 1'b1}) begin errs++; $display("FAIL rec130 got rec=%0d st=%b pas=%b exp 130 01 1", REC, ERR_STATE, FLAG_PASSIVE); end
    RX_OK = 1;
    step;
    vec++; if ({REC, ERR_STATE} !== {8'd120, 2'b00}) begin errs++; $display("FAIL rec_to_120 got rec=%0d st=%b exp 120 00", REC, ERR_STATE); end
    step;
    RX_OK = 0;
    vec++; if (REC !== 8'd119) begin errs++; $display("FAIL rec_dec got %0d exp 119", REC); end
    TX_OK = 1;
    step;
    TX_OK = 0;
    vec++; if (TEC !== 9'd0) begin errs++; $display("FAIL tec_floor got %0d exp 0", TEC); end
  endtask

  task test_reset_midop_timeout;
    apply_reset;
    repeat (4) begin
      err_req(1);
      step;
      finish_frame;
    end
    err_req(1);
    step;
    vec++; if ({BUSY, TEC} !== {1'b1, 9'd40}) begin errs++; $display("FAIL pre_reset got busy=%b tec=%0d exp 1 40", BUSY, TEC); end
    #2 reset = 1;
    #1;
    vec++; if ({F_OVRLD, FLAG_KIND, FLAG_PASSIVE, TEC, REC, ERR_STATE, BUSY} !== {1'b1, 2'b00, 9'd0, 8'd0, 2'b00, 1'b0}) begin errs++; $display("FAIL async_reset got %b exp 1_00_0_0_00_0", {F_OVRLD, FLAG_KIND, FLAG_PASSIVE, TEC, REC, ERR_STATE, BUSY}); end
    #1 reset = 0;
    err_req(1);
    vec++; if ({F_OVRLD, TEC} !== {1'b0, 9'd8}) begin errs++; $display("FAIL post_reset_req got ovrld=%b tec=%0d exp 0 8", F_OVRLD, TEC); end
    step;
    repeat (63) step;
    vec++; if (BUSY !== 1'b1) begin errs++; $display("FAIL tmo_early got busy=%b exp 1", BUSY); end
    step;
    vec++; if ({BUSY, F_OVRLD} !== 2'b01) begin errs++; $display("FAIL tmo_idle got busy=%b ovrld=%b exp 0 1", BUSY, F_OVRLD); end
  endtask

  initial begin
    test_reset;
    test_tx_error;
    test_passive_busoff;
    test_busoff_recovery;
    test_overload;
    test_simultaneous;
    test_reset_midop_timeout;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
